// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit that owns HI/LO.
// One shift-add or restoring-divide step per cycle over a shared 64-bit accumulator.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [ITER-1:0] rs_data,
  input  logic [ITER-1:0] rt_data,
  output logic            busy,
  output logic            done,
  output logic [ITER-1:0] hi,
  output logic [ITER-1:0] lo
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2*ITER-1:0] acc;
  logic [ITER-1:0]   opnd;
  logic              is_div, neg_q, neg_r, dz;

  logic              signed_op;
  logic [ITER-1:0]   abs_rs, abs_rt;
  logic [ITER:0]     madd, rsh;
  logic [ITER+1:0]   diff;
  logic [2*ITER-1:0] mul_nxt, div_nxt, step_nxt, prod_fix;
  logic [ITER-1:0]   quo_fix, rem_fix;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign abs_rs = (signed_op && rs_data[ITER-1]) ? (~rs_data + 1'b1) : rs_data;
  assign abs_rt = (signed_op && rt_data[ITER-1]) ? (~rt_data + 1'b1) : rt_data;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
  assign madd    = {1'b0, acc[2*ITER-1:ITER]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {madd, acc[ITER-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifting left.
  assign rsh     = {acc[2*ITER-1:ITER], acc[ITER-1]};
  assign diff    = {1'b0, rsh} - {2'b0, opnd};
  assign div_nxt = diff[ITER+1] ? {rsh[ITER-1:0], acc[ITER-2:0], 1'b0}
                                : {diff[ITER-1:0], acc[ITER-2:0], 1'b1};

  assign step_nxt = is_div ? div_nxt : mul_nxt;
  assign prod_fix = neg_q ? (~step_nxt + 1'b1) : step_nxt;
  assign quo_fix  = neg_q ? (~step_nxt[ITER-1:0] + 1'b1) : step_nxt[ITER-1:0];
  // With a zero divisor the remainder ends up as |rs|, so sign-fixing restores rs.
  assign rem_fix  = neg_r ? (~step_nxt[2*ITER-1:ITER] + 1'b1) : step_nxt[2*ITER-1:ITER];

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == S_RUN) begin
      acc <= step_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state <= S_DONE;
        if (is_div) begin
          hi <= rem_fix;
          lo <= dz ? '1 : quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end else begin
      state <= S_IDLE;
      if (start) begin
        if (op == OP_MTHI) begin
          hi <= rs_data;
        end else if (op == OP_MTLO) begin
          lo <= rs_data;
        end else if (!op[2]) begin
          state  <= S_RUN;
          cnt    <= '0;
          is_div <= op[1];
          opnd   <= op[1] ? abs_rt : abs_rs;
          acc    <= {{ITER{1'b0}}, (op[1] ? abs_rs : abs_rt)};
          neg_q  <= signed_op && (rs_data[ITER-1] ^ rt_data[ITER-1]);
          neg_r  <= (op == OP_DIV) && rs_data[ITER-1];
          dz     <= (rt_data == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: transaction-level model compared every cycle,
// plus directed vectors with hand-computed HI/LO values and latency checks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    case (o)
      3'd0: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      3'd1: p = {32'b0, a} * {32'b0, b};
      3'd2: begin
        sa = int'(a);
        sb = int'(b);
        if (b == 0)                                 p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == '1)     p = {32'h0, 32'h8000_0000};
        else                                        p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_done;
  int          m_left;
  logic [63:0] m_pend;

  // Timing model: an accepted mult/div retires 32 edges after the accepting edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_left <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= m_pend;
          m_done <= 1'b1;
        end
      end
      if (start && m_left == 0) begin
        if (op <= 3'd3) begin
          m_pend <= ref_result(op, rs_data, rt_data);
          m_left <= 32;
        end else if (op == 3'd4) m_hi <= rs_data;
        else if (op == 3'd5)     m_lo <= rs_data;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit inj);
    int n;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        chk("busy_after_accept", busy, 1);
      end
      if (inj && n == 10) begin
        start = 1'b1; op = 3'd5; rs_data = 32'h1234;
      end
      if (inj && n == 11) begin
        start = 1'b0; op = o;
      end
      if (n == 32) chk("busy_last_iter", busy, 1);
    end while (!done && n < 40);
    chk("latency", n, 33);
    chk("busy_at_done", busy, 0);
    chk("hi_lit", hi, exp_hi);
    chk("lo_lit", lo, exp_lo);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        chk("model_busy", busy, (m_left > 0));
        chk("model_done", done, m_done);
        chk("model_hi", hi, m_hi);
        chk("model_lo", lo, m_lo);
      end
    join_none
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    @(negedge clk);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    @(negedge clk);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    @(negedge clk);
    run_op(3'd3, 32'd7,         32'd2,         32'd1,         32'd3,         0);
    @(negedge clk);
    run_op(3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 0);
    @(negedge clk);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0);
    @(negedge clk);
    run_op(3'd2, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    // mtlo arriving mid-multiply must not disturb the result
    run_op(3'd0, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 1);
    @(negedge clk);
    run_op(3'd0, 32'd2,         32'd3,         32'd0,         32'd6,         0);
    chk("done_before_b2b", done, 1);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         0);

    start = 1'b1; op = 3'd4; rs_data = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_hi", hi, 32'hAAAA_5555);
    chk("mthi_lo", lo, 32'd1);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);

    start = 1'b1; op = 3'd6;
    @(negedge clk);
    start = 1'b0;
    chk("rsvd_busy", busy, 0);

    start = 1'b1; op = 3'd2; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_done_after_rst", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
